uvmf_hdl_channel_arbiter: RTL and testbench
===========================================

UVMF_HDL_CHANNEL_ARBITER -- requirements
Module: uvmf_hdl_channel_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, beat payload width.
REQ-003 SHALL have parameter WDOG_CYCLES, default 16, stall limit used only when the watchdog is compiled in (legal 2..255).
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester beat valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last, input, NUM_REQ, per-requester last beat of packet.
REQ-009 SHALL have port req_ready, output, NUM_REQ, per-requester beat accepted.
REQ-010 SHALL have port out_valid, output, 1; out_data, output, DATA_WIDTH; out_last, output, 1: shared channel toward the emulator transactor.
REQ-011 SHALL have port out_ready, input, 1, channel backpressure.
REQ-012 SHALL have port grant_id, output, GW = max(1, clog2(NUM_REQ)), index of current owner.
REQ-013 SHALL have port busy, output, 1, high while a packet grant is held.
REQ-014 SHALL have port wdog_err, output, 1, one-cycle pulse on watchdog abort.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-016 IDLE: if any req_valid is high, next state BUSY; grant_id registered as the first requester with req_valid high, searching from rr_ptr upward with wrap NUM_REQ-1 -> 0.
REQ-017 IDLE: out_valid, out_last, all req_ready SHALL be 0; out_data SHALL be 0.
REQ-018 BUSY: out_valid = req_valid[grant_id], out_data/out_last = owner's data/last; req_ready[grant_id] = out_ready; all other req_ready = 0 (combinational pass-through, zero added latency per beat).
REQ-019 Grant latency: one cycle from req_valid in IDLE to the first beat presented on the channel.
REQ-020 BUSY to IDLE only when out_valid & out_ready & out_last in the same cycle; rr_ptr <= grant_id+1 modulo NUM_REQ.
REQ-021 Grant SHALL be locked for the whole packet; owner dropping req_valid mid-packet holds the grant and drives out_valid low.
REQ-022 Single-beat packet (req_last on first beat) SHALL complete in one BUSY cycle.
REQ-023 At least one IDLE cycle SHALL separate consecutive packets.
REQ-024 Requests from non-owners during BUSY SHALL be ignored until the next IDLE arbitration.
REQ-025 busy SHALL equal (state == BUSY).

Reset
REQ-026 reset high SHALL asynchronously force state IDLE, rr_ptr 0, grant_id 0, busy 0, wdog_err 0, out_valid 0, out_last 0, out_data 0, req_ready all 0.
REQ-027 Reset mid-packet SHALL abandon the packet; no beat accepted in the reset cycle; arbitration restarts from requester 0.

Configuration
REQ-028 Macro UVMF_HDL_ARB_WATCHDOG_EN defined: an 8-bit stall counter SHALL clear on entry to BUSY and on every accepted beat, increment each BUSY cycle with no accepted beat; on reaching WDOG_CYCLES, next state IDLE, rr_ptr <= grant_id+1, wdog_err pulses for exactly one cycle.
REQ-029 Macro undefined: no counter logic; wdog_err SHALL be tied 0; packets may stall indefinitely.

Verification
REQ-030 req_valid=4'b0110 in IDLE, rr_ptr 0 -> grant_id=1 one cycle later; after its last beat rr_ptr=2; next grant_id=2.
REQ-031 Requester 3 sends 3-beat packet with out_ready toggling 1,0,1,1 -> exactly 3 beats on channel, data in order, req_ready[0..2]=0 throughout.
REQ-032 All four requesting continuously with single-beat packets -> grants 0,1,2,3,0 with one IDLE cycle between each.
REQ-033 Reset asserted mid-packet on beat 2 of 4 -> all outputs 0 same cycle; after release with req_valid=4'b1000, grant_id=3.
REQ-034 Watchdog built, WDOG_CYCLES=16, owner holds req_valid low 16 cycles -> wdog_err one-cycle pulse, FSM IDLE, next grant to next requester; unbuilt -> grant held, wdog_err 0.

Source files
------------

// File: rtl/uvmf_hdl_channel_arbiter.sv
// Round-robin packet arbiter: grants one of NUM_REQ beat streams the shared channel for a whole packet.
// Define UVMF_HDL_ARB_WATCHDOG_EN to build the stall watchdog that aborts a packet stalled for WDOG_CYCLES.
module uvmf_hdl_channel_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int WDOG_CYCLES = 16,
  localparam int GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          wdog_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic          found;
  int            k;
  logic          accept;
  logic          done;
  logic          wdog_fire;

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick  = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[k]) begin
        found = 1'b1;
        pick  = GW'(k);
      end
    end
  end

  // Beats pass straight through from the owner; nothing is driven while idle.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (state == BUSY) begin
      out_valid           = req_valid[grant_id];
      out_last            = req_last[grant_id];
      out_data            = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      req_ready[grant_id] = out_ready;
    end
  end

  assign accept = out_valid & out_ready;
  assign done   = accept & out_last;
  assign busy   = (state == BUSY);

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          state    <= BUSY;
          grant_id <= pick;
        end
        BUSY: if (done || wdog_fire) begin
          state  <= IDLE;
          rr_ptr <= next_idx(grant_id);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UVMF_HDL_ARB_WATCHDOG_EN
  localparam logic [7:0] STALL_MAX = 8'(WDOG_CYCLES - 1);

  logic [7:0] stall_cnt;
  logic       wdog_pulse;

  // Fires on the cycle the count would reach WDOG_CYCLES.
  assign wdog_fire = busy && !accept && (stall_cnt == STALL_MAX);
  assign wdog_err  = wdog_pulse;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      wdog_pulse <= 1'b0;
    end else begin
      wdog_pulse <= wdog_fire;
      if (!busy || accept) stall_cnt <= '0;
      else                 stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  logic wdog_cfg_unused;

  // Stall limit has no effect without the watchdog; packets may stall forever.
  assign wdog_cfg_unused = ^8'(WDOG_CYCLES);
  assign wdog_fire       = 1'b0;
  assign wdog_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uvmf_hdl_channel_arbiter.sv
// Bench for uvmf_hdl_channel_arbiter: vector table for arbitration order plus hand-written
// multi-cycle sequences; accepted channel beats are checked against a scoreboard queue.
module tb_uvmf_hdl_channel_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clock;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             out_ready;
  logic [1:0]       grant_id;
  logic             busy;
  logic             wdog_err;

  uvmf_hdl_channel_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .WDOG_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic [3:0] rl;
    logic       ordy;
    logic       eb;
    logic [1:0] eg;
    logic       ev;
    logic       el;
    logic [3:0] er;
  } vec_t;

  vec_t            tbl[$];
  logic [DW:0]     sb_q[$];
  int              vectors = 0;
  int              miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int i);
    return req_data[i*DW +: DW];
  endfunction

  // Control outputs packed as {busy, grant_id, out_valid, out_last, req_ready, wdog_err}.
  task automatic expect_out(input string name, input logic eb, input logic [1:0] eg,
                            input logic ev, input logic el, input logic [3:0] er, input logic ew);
    check({name, "_ctl"}, 64'({busy, grant_id, out_valid, out_last, req_ready, wdog_err}),
          64'({eb, eg, ev, el, er, ew}));
    check({name, "_data"}, 64'(out_data), eb ? 64'(dat(int'(eg))) : 64'd0);
  endtask

  // Drive one cycle's inputs just after the rising edge; the caller checks at the falling edge.
  task automatic step(input logic rst, input logic [3:0] rv, input logic [3:0] rl, input logic ordy);
    @(posedge clock);
    #1;
    // NOTE: bench stimulus uses blocking assignments from procedural code, well away from the edge.
    reset     = rst;
    req_valid = rv;
    req_last  = rl;
    out_ready = ordy;
  endtask

  task automatic push_beat(input int gid, input logic last);
    sb_q.push_back({dat(gid), last});
  endtask

  task automatic add(input logic rst, input logic [3:0] rv, input logic [3:0] rl, input logic ordy,
                     input logic eb, input logic [1:0] eg, input logic ev, input logic el,
                     input logic [3:0] er);
    tbl.push_back('{rst, rv, rl, ordy, eb, eg, ev, el, er});
  endtask

  // Scoreboard monitor: every accepted channel beat must match the oldest expected beat.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", 64'({out_data, out_last}), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_beat", 64'({out_data, out_last}), 64'(e));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);

    repeat (2) @(negedge clock);
    expect_out("reset", 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // rr_ptr=0 with 0110 -> 1, then rr_ptr=2 -> 2, one idle cycle between packets.
    add(0, 4'b0110, 4'b0110, 1, 0, 2'd0, 0, 0, 4'b0000);
    add(0, 4'b0110, 4'b0110, 1, 1, 2'd1, 1, 1, 4'b0010);
    add(0, 4'b0110, 4'b0110, 1, 0, 2'd1, 0, 0, 4'b0000);
    add(0, 4'b0110, 4'b0110, 1, 1, 2'd2, 1, 1, 4'b0100);
    // Reset during idle, then all four requesting single-beat packets: 0,1,2,3,0.
    add(1, 4'b1111, 4'b1111, 1, 0, 2'd0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 0, 2'd0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 1, 2'd0, 1, 1, 4'b0001);
    add(0, 4'b1111, 4'b1111, 1, 0, 2'd0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 1, 2'd1, 1, 1, 4'b0010);
    add(0, 4'b1111, 4'b1111, 1, 0, 2'd1, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 1, 2'd2, 1, 1, 4'b0100);
    add(0, 4'b1111, 4'b1111, 1, 0, 2'd2, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 1, 2'd3, 1, 1, 4'b1000);
    add(0, 4'b1111, 4'b1111, 1, 0, 2'd3, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 1, 2'd0, 1, 1, 4'b0001);
    add(0, 4'b0000, 4'b0000, 1, 0, 2'd0, 0, 0, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].rl, tbl[i].ordy);
      if (tbl[i].ev && tbl[i].ordy) push_beat(int'(tbl[i].eg), tbl[i].el);
      @(negedge clock);
      expect_out($sformatf("vec%0d", i), tbl[i].eb, tbl[i].eg, tbl[i].ev, tbl[i].el, tbl[i].er, 1'b0);
    end

    // Requester 3 three-beat packet with out_ready 1,0,1,1; others request but are ignored.
    step(0, 4'b1000, 4'b0000, 1);
    @(negedge clock); expect_out("p3_arb", 0, 2'd0, 0, 0, 4'b0000, 0);
    req_data[3*DW +: DW] = 32'h3000_0000;
    step(0, 4'b1111, 4'b0000, 1); push_beat(3, 0);
    @(negedge clock); expect_out("p3_b0", 1, 2'd3, 1, 0, 4'b1000, 0);
    req_data[3*DW +: DW] = 32'h3000_0001;
    step(0, 4'b1111, 4'b0000, 0);
    @(negedge clock); expect_out("p3_stall", 1, 2'd3, 1, 0, 4'b0000, 0);
    step(0, 4'b1111, 4'b0000, 1); push_beat(3, 0);
    @(negedge clock); expect_out("p3_b1", 1, 2'd3, 1, 0, 4'b1000, 0);
    req_data[3*DW +: DW] = 32'h3000_0002;
    step(0, 4'b1111, 4'b1000, 1); push_beat(3, 1);
    @(negedge clock); expect_out("p3_b2", 1, 2'd3, 1, 1, 4'b1000, 0);
    step(0, 4'b0111, 4'b0111, 1);
    @(negedge clock); expect_out("p3_gap", 0, 2'd3, 0, 0, 4'b0000, 0);
    step(0, 4'b0001, 4'b0001, 1); push_beat(0, 1);
    @(negedge clock); expect_out("p3_next", 1, 2'd0, 1, 1, 4'b0001, 0);

    // Reset on beat 2 of a 4-beat packet from requester 0 (rr_ptr=1 wraps to 0).
    step(0, 4'b0001, 4'b0000, 1);
    @(negedge clock); expect_out("rst_arb", 0, 2'd0, 0, 0, 4'b0000, 0);
    step(0, 4'b0001, 4'b0000, 1); push_beat(0, 0);
    @(negedge clock); expect_out("rst_b1", 1, 2'd0, 1, 0, 4'b0001, 0);
    step(0, 4'b0001, 4'b0000, 1);
    #2 reset = 1'b1;
    @(negedge clock); expect_out("rst_mid", 0, 2'd0, 0, 0, 4'b0000, 0);
    step(0, 4'b1000, 4'b1000, 1);
    @(negedge clock); expect_out("rst_rel", 0, 2'd0, 0, 0, 4'b0000, 0);
    step(0, 4'b1000, 4'b1000, 1); push_beat(3, 1);
    @(negedge clock); expect_out("rst_g3", 1, 2'd3, 1, 1, 4'b1000, 0);

    // Owner 1 drops req_valid mid-packet and stalls.
    step(0, 4'b0010, 4'b0000, 1);
    @(negedge clock); expect_out("wd_arb", 0, 2'd3, 0, 0, 4'b0000, 0);
`ifdef UVMF_HDL_ARB_WATCHDOG_EN
    for (int c = 0; c < 17; c++) begin
      step(0, 4'b0000, 4'b0000, 1);
      @(negedge clock);
      if (c < 16) expect_out($sformatf("wd_stall%0d", c), 1, 2'd1, 0, 0, 4'b0010, 0);
      else        expect_out("wd_abort", 0, 2'd1, 0, 0, 4'b0000, 1);
    end
    step(0, 4'b0110, 4'b0110, 1);
    @(negedge clock); expect_out("wd_pulse_end", 0, 2'd1, 0, 0, 4'b0000, 0);
    step(0, 4'b0110, 4'b0110, 1); push_beat(2, 1);
    @(negedge clock); expect_out("wd_next", 1, 2'd2, 1, 1, 4'b0100, 0);
`else
    for (int c = 0; c < 20; c++) begin
      step(0, 4'b0000, 4'b0000, 1);
      @(negedge clock);
      expect_out($sformatf("hold%0d", c), 1, 2'd1, 0, 0, 4'b0010, 0);
    end
    step(0, 4'b0010, 4'b0010, 1); push_beat(1, 1);
    @(negedge clock); expect_out("hold_done", 1, 2'd1, 1, 1, 4'b0010, 0);
`endif
    step(0, 4'b0000, 4'b0000, 1);
    @(negedge clock); expect_out("final_idle", 0, grant_id === 2'd2 ? 2'd2 : 2'd1, 0, 0, 4'b0000, 0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
